// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_packer
// Purpose  : Pops DATA_WIDTH-wide elements from a show-ahead async FIFO and
//            packs PACK of them into one little-endian output word (lane 0 is
//            the first element popped). A flush request emits a partially
//            filled word with a lane-valid mask. The output is a single
//            register slot with valid/ready handshake.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   rclk        in   read-domain clock, all state changes on rising edge
//   rrst        in   asynchronous active-high reset
//   fifo_data   in   head element of upstream FIFO (valid when !fifo_empty)
//   fifo_empty  in   upstream FIFO empty flag
//   fifo_r_en   out  pop request (combinational)
//   flush       in   single-cycle request to emit a partial word
//   out_data    out  packed word, lane 0 in the low bits
//   out_keep    out  lane-valid mask for out_data
//   out_valid   out  output slot holds a word
//   out_ready   in   downstream accepts when out_valid && out_ready
//   flush_busy  out  high while the flush state is active
//   word_count  out  number of accepted words, wraps at 16 bits
// ============================================================================
module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  input  logic                       fifo_empty,
  output logic                       fifo_r_en,
  input  logic                       flush,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]            out_keep,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       flush_busy,
  output logic [15:0]                word_count
);

  localparam int             c_CW   = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(PACK - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);
  localparam int             c_AW   = DATA_WIDTH * (PACK - 1);

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t                      r_state, w_nxt_state;
  logic [c_CW-1:0]             r_cnt, w_nxt_cnt;
  logic [c_AW-1:0]             r_acc, w_nxt_acc;
  logic [DATA_WIDTH*PACK-1:0]  r_out_data, w_nxt_data;
  logic [PACK-1:0]             r_out_keep, w_nxt_keep;
  logic                        r_out_valid, w_nxt_valid;
  logic [15:0]                 r_word_count;

  logic w_stall;
  logic w_pop;
  logic w_accept;

  // The final lane may only be popped if the output slot is free or is being
  // emptied on this same edge; otherwise the word in the slot would be lost.
  assign w_stall  = (r_cnt == c_LAST) && r_out_valid && !out_ready;
  assign w_pop    = !rrst && (r_state == S_FILL) && !fifo_empty && !w_stall;
  assign w_accept = r_out_valid && out_ready;

  assign fifo_r_en  = w_pop;
  assign out_data   = r_out_data;
  assign out_keep   = r_out_keep;
  assign out_valid  = r_out_valid;
  assign flush_busy = (r_state == S_FLUSH);
  assign word_count = r_word_count;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_state      <= S_FILL;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_out_data   <= '0;
      r_out_keep   <= '0;
      r_out_valid  <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_acc       <= w_nxt_acc;
      r_out_data  <= w_nxt_data;
      r_out_keep  <= w_nxt_keep;
      r_out_valid <= w_nxt_valid;
      if (w_accept) begin
        r_word_count <= r_word_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_acc   = r_acc;
    w_nxt_data  = r_out_data;
    w_nxt_keep  = r_out_keep;
    // A word loaded below overrides this, keeping back-to-back words bubble-free.
    w_nxt_valid = r_out_valid && !w_accept;

    case (r_state)
      S_FILL: begin
        if (w_pop) begin
          if (r_cnt == c_LAST) begin
            w_nxt_data  = {fifo_data, r_acc};
            w_nxt_keep  = '1;
            w_nxt_valid = 1'b1;
            w_nxt_cnt   = '0;
          end else begin
            for (int i = 0; i < PACK - 1; i++) begin
              if (int'(r_cnt) == i) begin
                w_nxt_acc[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
              end
            end
            w_nxt_cnt = r_cnt + c_ONE;
          end
        end
        // A pop taken in the same cycle is already folded into the counters
        // above, so the flush that follows includes it.
        if (flush) begin
          w_nxt_state = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (r_cnt == '0) begin
          w_nxt_state = S_FILL;
        end else if (!r_out_valid || out_ready) begin
          w_nxt_data = '0;
          w_nxt_keep = '0;
          for (int i = 0; i < PACK - 1; i++) begin
            if (i < int'(r_cnt)) begin
              w_nxt_data[i*DATA_WIDTH +: DATA_WIDTH] = r_acc[i*DATA_WIDTH +: DATA_WIDTH];
              w_nxt_keep[i] = 1'b1;
            end
          end
          w_nxt_valid = 1'b1;
          w_nxt_cnt   = '0;
          w_nxt_state = S_FILL;
        end
      end

      default: begin
        w_nxt_state = S_FILL;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_word_packer
// Purpose  : Directed self-checking bench for fifo_word_packer (DATA_WIDTH=8,
//            PACK=4). A small show-ahead FIFO model feeds the DUT; expected
//            values are hand-computed constants.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_word_packer;

  logic        rclk;
  logic        rrst;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic        fifo_r_en;
  logic        flush;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready;
  logic        flush_busy;
  logic [15:0] word_count;

  int n_pass  = 0;
  int n_total = 0;

  // Show-ahead FIFO model; inf forces a never-empty source.
  logic [7:0] mem [0:255];
  logic [7:0] rd = 8'd0;
  logic [7:0] wr;
  logic       inf;

  assign fifo_empty = inf ? 1'b0 : (rd == wr);
  assign fifo_data  = mem[rd];

  always @(posedge rclk) begin
    if (fifo_r_en) rd <= rd + 8'd1;
  end

  fifo_word_packer #(.DATA_WIDTH(8), .PACK(4)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .flush      (flush),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush_busy (flush_busy),
    .word_count (word_count)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr] = b;
    wr = wr + 8'd1;
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  // Called just after an edge; pulse is short and far from the next edge.
  task automatic pulse_reset();
    rrst = 1'b1;
    #1;
    wr = rd;
    #1;
    rrst = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_data"},  64'(out_data),   64'h0);
    chk({tag, "_keep"},  64'(out_keep),   64'h0);
    chk({tag, "_valid"}, 64'(out_valid),  64'h0);
    chk({tag, "_wc"},    64'(word_count), 64'h0);
    chk({tag, "_busy"},  64'(flush_busy), 64'h0);
    chk({tag, "_ren"},   64'(fifo_r_en),  64'h0);
  endtask

  initial begin
    rrst      = 1'b1;
    wr        = 8'd0;
    inf       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state: data present in FIFO yet no pop while reset is held.
    push(8'hEE);
    #1;
    chk_idle("reset");
    wr = rd;
    tick();
    rrst = 1'b0;

    // Four bytes -> one word on the 4th pop edge.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1;
    chk("t1_ren0", 64'(fifo_r_en), 64'h1);
    tick(); tick(); tick();
    chk("t1_valid_e3", 64'(out_valid), 64'h0);
    tick();
    chk("t1_valid_e4", 64'(out_valid), 64'h1);
    chk("t1_data",     64'(out_data),  64'h44332211);
    chk("t1_keep",     64'(out_keep),  64'hF);
    chk("t1_wc_e4",    64'(word_count), 64'h0);
    tick();
    chk("t1_wc_e5",    64'(word_count), 64'h1);
    chk("t1_valid_e5", 64'(out_valid),  64'h0);

    // Eight bytes continuous: two words, pop every cycle.
    pulse_reset();
    for (int i = 1; i <= 8; i++) push(8'(i));
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_ren_%0d", i), 64'(fifo_r_en), 64'h1);
      tick();
      if (i == 3) chk("t2_word1", 64'(out_data), 64'h04030201);
    end
    chk("t2_word2",  64'(out_data),  64'h08070605);
    chk("t2_valid2", 64'(out_valid), 64'h1);
    chk("t2_keep2",  64'(out_keep),  64'hF);
    tick();
    chk("t2_wc", 64'(word_count), 64'h2);
    chk("t2_ren_end", 64'(fifo_r_en), 64'h0);

    // Back-pressure: first word held, three more pops, stall at cnt=3.
    pulse_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) push(8'hA0 + 8'(i));
    tick(); tick(); tick(); tick();
    chk("t3_w1", 64'(out_data), 64'hA4A3A2A1);
    tick(); tick(); tick();
    chk("t3_rd_after7", 64'(rd), 64'(wr));
    chk("t3_w1_held",   64'(out_data), 64'hA4A3A2A1);
    chk("t3_v_held",    64'(out_valid), 64'h1);
    push(8'hA8);
    #1;
    chk("t3_ren_stall", 64'(fifo_r_en), 64'h0);
    tick();
    chk("t3_w1_held2",  64'(out_data), 64'hA4A3A2A1);
    chk("t3_no_pop",    64'(8'(wr - rd)), 64'h1);
    out_ready = 1'b1;
    #1;
    chk("t3_ren_go", 64'(fifo_r_en), 64'h1);
    tick();
    chk("t3_w2",     64'(out_data),   64'hA8A7A6A5);
    chk("t3_v2",     64'(out_valid),  64'h1);
    chk("t3_wc1",    64'(word_count), 64'h1);
    tick();
    chk("t3_wc2",    64'(word_count), 64'h2);
    chk("t3_v_end",  64'(out_valid),  64'h0);

    // Flush of a partial word, then flush with nothing accumulated.
    pulse_reset();
    push(8'hAA); push(8'hBB);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_busy1",  64'(flush_busy), 64'h1);
    chk("t4_ren_fl", 64'(fifo_r_en),  64'h0);
    tick();
    chk("t4_busy0",  64'(flush_busy), 64'h0);
    chk("t4_data",   64'(out_data),   64'h0000BBAA);
    chk("t4_keep",   64'(out_keep),   64'h3);
    chk("t4_valid",  64'(out_valid),  64'h1);
    tick();
    chk("t4_wc",     64'(word_count), 64'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_e_busy1", 64'(flush_busy), 64'h1);
    tick();
    chk("t4_e_busy0", 64'(flush_busy), 64'h0);
    chk("t4_e_valid", 64'(out_valid),  64'h0);
    chk("t4_e_wc",    64'(word_count), 64'h1);

    // Reset mid-word discards partial data.
    pulse_reset();
    push(8'h01); push(8'h02);
    tick(); tick();
    rrst = 1'b1;
    #1;
    chk_idle("t5_rst");
    rrst = 1'b0;
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    tick(); tick(); tick(); tick();
    chk("t5_data",  64'(out_data),  64'h88776655);
    chk("t5_keep",  64'(out_keep),  64'hF);
    chk("t5_valid", 64'(out_valid), 64'h1);

    // word_count wrap: one single-lane flushed word every two cycles.
    pulse_reset();
    inf       = 1'b1;
    flush     = 1'b1;
    out_ready = 1'b1;
    repeat (131071) @(posedge rclk);
    #1;
    chk("t6_wc_ffff", 64'(word_count), 64'hFFFF);
    tick(); tick();
    chk("t6_wc_wrap", 64'(word_count), 64'h0);
    inf   = 1'b0;
    flush = 1'b0;
    pulse_reset();
    tick();
    chk_idle("t6_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
